// File: rtl/cpu_debug_ctrl_pkg.sv
// cpu_debug_pkg: state encoding and synchronizer depth shared by cpu_debug_ctrl and its key front ends
package cpu_debug_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BREAK = 2'd3} state_e;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/cpu_debug_ctrl_key.sv
// key_edge_detect: synchronizes a raw key level and emits one pulse per rising edge
module key_edge_detect
  import cpu_debug_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);
  logic [SYNC_STAGES:0] sync_q;
  logic [SYNC_STAGES:0] arm_q;
  // top stage of sync_q holds the previous synchronized level; arm_q masks edges until that stage
  // carries a real post-reset sample, so a key already held when reset releases never pulses
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], key_i};
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES] & arm_q[SYNC_STAGES];
endmodule

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: run/step/halt debug controller; breakpoint support under CPU_DEBUG_BREAKPOINT_EN
module cpu_debug_ctrl
  import cpu_debug_pkg::*;
#(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int W_REG     = 5,
  parameter int RESET_REG = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_key,
  input  logic              step_key,
  input  logic              halt_key,
  input  logic              sel_key,
  input  logic              disp_sel,
  input  logic [W_ADDR-1:0] im_addr,
  input  logic [W_DATA-1:0] reg_data,
  input  logic [W_ADDR-1:0] bp_addr,
  input  logic              bp_valid,
  output logic              cpu_clk_en,
  output logic [W_REG-1:0]  reg_addr,
  output logic [W_DATA-1:0] display_value,
  output logic [1:0]        state,
  output logic [31:0]       instr_count
);
  state_e state_q, state_d;
  logic run_p, step_p, halt_p, sel_p, bp_hit;
  logic [W_REG-1:0] reg_addr_q;
  logic [W_DATA-1:0] disp_q;
  logic [31:0] cnt_q;
  key_edge_detect u_run  (.clk(clk), .rst(rst), .key_i(run_key),  .pulse_o(run_p));
  key_edge_detect u_step (.clk(clk), .rst(rst), .key_i(step_key), .pulse_o(step_p));
  key_edge_detect u_halt (.clk(clk), .rst(rst), .key_i(halt_key), .pulse_o(halt_p));
  key_edge_detect u_sel  (.clk(clk), .rst(rst), .key_i(sel_key),  .pulse_o(sel_p));
`ifdef CPU_DEBUG_BREAKPOINT_EN
  logic skip_bp_q, skip_bp_d;
  assign bp_hit = bp_valid && im_addr == bp_addr && !skip_bp_q;
  // leaving BREAK arms a one-shot bypass so the breakpoint instruction executes once on resume
  always_comb skip_bp_d = state_q == BREAK && (state_d == RUN || state_d == STEP) ? 1'b1 : cpu_clk_en ? 1'b0 : skip_bp_q;
  // bypass flag register
  always_ff @(posedge clk) skip_bp_q <= rst ? 1'b0 : skip_bp_d;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_addr};
  assign bp_hit = 1'b0;
`endif
  assign cpu_clk_en = state_q == STEP || (state_q == RUN && !bp_hit);
  // halt wins from any state; STEP lasts one cycle; RUN ignores step/run and stops before a breakpoint
  always_comb state_d = halt_p || state_q == STEP ? HALT :
                        state_q == RUN ? (bp_hit ? BREAK : RUN) :
                        step_p ? STEP : run_p ? RUN : state_q;
  // state, register pointer, display latch and executed-instruction counter
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= HALT;
      reg_addr_q <= W_REG'(RESET_REG);
      disp_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      reg_addr_q <= reg_addr_q + W_REG'(sel_p);
      disp_q     <= disp_sel ? reg_data : W_DATA'(im_addr);
      cnt_q      <= cnt_q + 32'(cpu_clk_en);
    end
  assign reg_addr      = reg_addr_q;
  assign display_value = disp_q;
  assign state         = state_q;
  assign instr_count   = cnt_q;
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb_cpu_debug_ctrl: directed and random checks of cpu_debug_ctrl against a behavioural model
module tb_cpu_debug_ctrl;
`ifdef CPU_DEBUG_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic clk = 1'b0, rst, run_key, step_key, halt_key, sel_key, disp_sel, bp_valid, cpu_clk_en;
  logic [31:0] im_addr, reg_data, bp_addr, display_value, instr_count;
  logic [4:0] reg_addr;
  logic [1:0] state;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;

  cpu_debug_ctrl dut (
    .clk(clk), .rst(rst), .run_key(run_key), .step_key(step_key), .halt_key(halt_key),
    .sel_key(sel_key), .disp_sel(disp_sel), .im_addr(im_addr), .reg_data(reg_data),
    .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_clk_en(cpu_clk_en), .reg_addr(reg_addr),
    .display_value(display_value), .state(state), .instr_count(instr_count)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", n, got, exp, $time);
    end
  endtask

  // model: states 0=halt 1=run 2=step 3=break; key levels seen at the last three edges
  int m_state, since;
  logic [4:0] m_reg;
  logic [31:0] m_disp, m_cnt, pc;
  bit m_skip;
  logic [3:0] h0, h1, h2, p;

  function automatic bit m_hit();
    return BP && bp_valid && im_addr == bp_addr && !m_skip;
  endfunction
  function automatic bit m_en();
    return m_state == 2 || (m_state == 1 && !m_hit());
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_reg = 5'd10; m_disp = 0; m_cnt = 0; m_skip = 0; pc = 0;
      h0 = 0; h1 = 0; h2 = 0; since = 0;
    end else begin
      int nxt;
      bit en;
      p = h1 & ~h2 & {4{since >= 3}};
      en = m_en();
      nxt = m_state;
      if (p[2] || m_state == 2) nxt = 0;
      else if (m_state == 1) nxt = m_hit() ? 3 : 1;
      else if (p[1]) nxt = 2;
      else if (p[0]) nxt = 1;
      if (BP && m_state == 3 && (nxt == 1 || nxt == 2)) m_skip = 1;
      else if (en) m_skip = 0;
      m_state = nxt;
      m_cnt = m_cnt + 32'(en);
      m_reg = m_reg + 5'(p[3]);
      m_disp = disp_sel ? reg_data : im_addr;
      if (en) pc = pc + 4;
      h2 = h1; h1 = h0; h0 = {sel_key, halt_key, step_key, run_key};
      since = since < 3 ? since + 1 : 3;
    end
  end

  always @(negedge clk) if (chk_on) begin
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("cpu_clk_en", 32'(cpu_clk_en), 32'(m_en()));
    chk("reg_addr", 32'(reg_addr), 32'(m_reg));
    chk("display_value", display_value, m_disp);
    chk("instr_count", instr_count, m_cnt);
  end

  task automatic tick();
    @(negedge clk);
    im_addr = pc;
  endtask

  initial begin
    int en_seen, w;
    rst = 1; run_key = 0; step_key = 0; halt_key = 0; sel_key = 0;
    disp_sel = 0; reg_data = 0; bp_addr = 0; bp_valid = 0; im_addr = 0;
    tick(); tick(); chk_on = 1; tick();
    rst = 0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_reg", 32'(reg_addr), 10);
    chk("rst_en", 32'(cpu_clk_en), 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_disp", display_value, 0);
    tick(); step_key = 1; en_seen = 0;
    repeat (5) begin tick(); #2; en_seen += 32'(cpu_clk_en); end
    step_key = 0;
    repeat (6) begin tick(); #2; en_seen += 32'(cpu_clk_en); end
    chk("step_en_cycles", en_seen, 1);
    chk("step_cnt", instr_count, 1);
    chk("step_state", 32'(state), 0);
    tick(); run_key = 1;
    repeat (3) tick();
    run_key = 0;
    repeat (27) tick();
    halt_key = 1;
    repeat (3) tick();
    halt_key = 0;
    repeat (5) tick();
    #2;
    chk("run_cnt", instr_count, 31);
    chk("run_halt_state", 32'(state), 0);
    chk("run_halt_en", 32'(cpu_clk_en), 0);
    tick(); run_key = 1; step_key = 1; halt_key = 1; en_seen = 0;
    repeat (3) begin tick(); #2; en_seen += 32'(cpu_clk_en); end
    run_key = 0; step_key = 0; halt_key = 0;
    repeat (5) begin tick(); #2; en_seen += 32'(cpu_clk_en); end
    chk("coincide_en", en_seen, 0);
    chk("coincide_state", 32'(state), 0);
    for (int i = 0; i < 32; i++) begin
      tick(); sel_key = 1;
      tick(); sel_key = 0;
      repeat (2) tick();
      #2;
      chk("sel_reg", 32'(reg_addr), (10 + i + 1) % 32);
    end
    tick(); disp_sel = 1; reg_data = 32'hDEADBEEF;
    tick(); #2;
    chk("disp_reg", display_value, 32'hDEADBEEF);
    disp_sel = 0;
`ifdef CPU_DEBUG_BREAKPOINT_EN
    tick(); rst = 1; tick(); tick(); rst = 0; bp_addr = 32'h10; bp_valid = 1;
    tick(); run_key = 1;
    repeat (3) tick();
    run_key = 0;
    repeat (12) tick();
    #2;
    chk("bp_state", 32'(state), 3);
    chk("bp_addr_held", im_addr, 32'h10);
    chk("bp_cnt", instr_count, 4);
    chk("bp_en", 32'(cpu_clk_en), 0);
    tick(); run_key = 1;
    repeat (3) tick();
    run_key = 0;
    repeat (10) tick();
    #2;
    chk("bp_resume_state", 32'(state), 1);
    chk("bp_resume_past", 32'(im_addr > 32'h10), 1);
    halt_key = 1;
    repeat (3) tick();
    halt_key = 0; bp_valid = 0;
    repeat (4) tick();
`endif
    tick(); rst = 1; run_key = 1;
    tick(); tick(); rst = 0;
    repeat (8) tick();
    #2;
    chk("held_key_state", 32'(state), 0);
    chk("held_key_cnt", instr_count, 0);
    run_key = 0;
    tick(); tick(); run_key = 1;
    repeat (3) tick();
    run_key = 0;
    w = 0;
    while (w < 300 && instr_count !== 32'd100) begin tick(); w++; end
    chk("cnt100_reached", instr_count, 100);
    rst = 1;
    tick(); #2;
    chk("midrun_rst_state", 32'(state), 0);
    chk("midrun_rst_cnt", instr_count, 0);
    chk("midrun_rst_reg", 32'(reg_addr), 10);
    chk("midrun_rst_en", 32'(cpu_clk_en), 0);
    rst = 0;
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 5) == 0) run_key = ~run_key;
      if ($urandom_range(0, 7) == 0) step_key = ~step_key;
      if ($urandom_range(0, 11) == 0) halt_key = ~halt_key;
      if ($urandom_range(0, 3) == 0) sel_key = ~sel_key;
      rst = $urandom_range(0, 299) == 0;
      disp_sel = 1'($urandom);
      reg_data = $urandom;
      bp_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) bp_addr = 4 * $urandom_range(0, 20);
    end
    rst = 0;
    tick(); tick(); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
